// File: rtl/multiport_register_file_sb_pkg.sv
// Shared types, default sizes and the bypass priority helper
// for the multiport register file.
package regfile_pkg;

  localparam int unsigned RF_DEFAULT_XLEN  = 32;
  localparam int unsigned RF_DEFAULT_NREGS = 32;
  localparam int unsigned RF_MAX_WR        = 4;

  typedef logic [$clog2(RF_DEFAULT_NREGS)-1:0] rf_addr_t;

  // Highest-index set bit of the match vector.
  // Callers qualify the result with |match.
  function automatic int unsigned rf_bypass_sel(input logic [RF_MAX_WR-1:0] match);
    int unsigned sel;
    sel = 0;
    for (int unsigned i = 0; i < RF_MAX_WR; i++) begin
      if (match[i]) sel = i;
    end
    return sel;
  endfunction

endpackage

// File: rtl/multiport_register_file_sb_if.sv
// Read, write, reserve and scoreboard signals of the register file.
interface multiport_register_file_sb_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 1
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [NUM_RD-1:0][AW-1:0]   rd_addr;
  logic [NUM_RD-1:0][XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]           rd_busy;
  logic [NUM_WR-1:0]           wr_en;
  logic [NUM_WR-1:0][AW-1:0]   wr_addr;
  logic [NUM_WR-1:0][XLEN-1:0] wr_data;
  logic                        rsv_en;
  logic [AW-1:0]               rsv_addr;
  logic [NREGS-1:0]            busy_vec;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_busy, busy_vec
  );

endinterface

// File: rtl/multiport_register_file_sb_scoreboard.sv
// Per-register busy bits: writes clear, reservations set, and a
// reservation beats a write to the same register in the same cycle.
module rf_scoreboard #(
  parameter int unsigned NREGS        = 32,
  parameter int unsigned NUM_WR       = 1,
  parameter int unsigned HAS_ZERO_REG = 1,
  parameter int unsigned AW           = $clog2(NREGS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_WR-1:0]         wr_en,
  input  logic [NUM_WR-1:0][AW-1:0] wr_addr,
  input  logic                      rsv_en,
  input  logic [AW-1:0]             rsv_addr,
  output logic [NREGS-1:0]          busy_vec
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      if (wr_en[w]) busy_d[wr_addr[w]] = 1'b0;
    end
    if (rsv_en) busy_d[rsv_addr] = 1'b1;
    if (HAS_ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/multiport_register_file_sb.sv
// Parametrised N-read / M-write register file with same-cycle write
// bypass and a busy scoreboard for RAW hazard detection at issue.
module multiport_register_file_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN         = RF_DEFAULT_XLEN,
  parameter int unsigned NREGS        = RF_DEFAULT_NREGS,
  parameter int unsigned NUM_RD       = 2,
  parameter int unsigned NUM_WR       = 1,
  parameter int unsigned HAS_ZERO_REG = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  multiport_register_file_sb_if.slave   bus
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [XLEN-1:0]          mem_q [NREGS];
  logic [XLEN-1:0]          mem_d [NREGS];
  logic [NREGS-1:0]         busy_vec;
  logic [RF_MAX_WR-1:0]     match;
  int unsigned              sel;

  rf_scoreboard #(
    .NREGS        (NREGS),
    .NUM_WR       (NUM_WR),
    .HAS_ZERO_REG (HAS_ZERO_REG),
    .AW           (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .rsv_en   (bus.rsv_en),
    .rsv_addr (bus.rsv_addr),
    .busy_vec (busy_vec)
  );

  assign bus.busy_vec = busy_vec;

  // Ascending port order makes the highest-index port win a collision.
  always_comb begin
    mem_d = mem_q;
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      if (bus.wr_en[w] && !(HAS_ZERO_REG != 0 && bus.wr_addr[w] == '0)) begin
        mem_d[bus.wr_addr[w]] = bus.wr_data[w];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Bypass is suppressed during reset since those writes are discarded.
  always_comb begin
    match       = '0;
    sel         = 0;
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      match = '0;
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        match[w] = !rst && bus.wr_en[w] && (bus.wr_addr[w] == bus.rd_addr[p]);
      end
      sel = rf_bypass_sel(match);
      bus.rd_data[p] = mem_q[bus.rd_addr[p]];
      bus.rd_busy[p] = busy_vec[bus.rd_addr[p]];
      if (|match) begin
        for (int unsigned w = 0; w < NUM_WR; w++) begin
          if (w == sel) bus.rd_data[p] = bus.wr_data[w];
        end
        bus.rd_busy[p] = 1'b0;
      end
      if (HAS_ZERO_REG != 0 && bus.rd_addr[p] == '0) begin
        bus.rd_data[p] = '0;
        bus.rd_busy[p] = 1'b0;
      end
    end
  end

endmodule
